// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Initiator in front of a combinational ALU. It owns a small register file and
// accepts LOAD / READ / EXEC commands on a valid/ready channel. For EXEC it
// fetches the operands into registered ALU inputs and writes the ALU result
// back. Every command produces exactly one response on a second valid/ready
// channel. One command is in flight at a time.
module alu_cmd_sequencer #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    // Command channel
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_kind,
    input  logic [2:0]    cmd_opcode,
    input  logic [AW-1:0] cmd_addr_a,
    input  logic [AW-1:0] cmd_addr_b,
    input  logic [AW-1:0] cmd_addr_d,
    input  logic [N-1:0]  cmd_imm,
    // ALU interface
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [2:0]    alu_opcode,
    input  logic [N-1:0]  alu_y,
    input  logic          alu_c,
    input  logic          alu_zero,
    // Response channel
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_data,
    output logic          rsp_c,
    output logic          rsp_zero,
    output logic          rsp_err
);

    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] KIND_EXEC = 2'b00;
    localparam logic [1:0] KIND_LOAD = 2'b01;
    localparam logic [1:0] KIND_READ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]  rf_q [DEPTH];

    logic [AW-1:0] addr_a_q;
    logic [AW-1:0] addr_b_q;
    logic [AW-1:0] addr_d_q;
    logic [2:0]    opcode_q;

    logic [N-1:0]  alu_a_q;
    logic [N-1:0]  alu_b_q;
    logic [2:0]    alu_opcode_q;

    logic [N-1:0]  rsp_data_q;
    logic          rsp_c_q;
    logic          rsp_zero_q;
    logic          rsp_err_q;

    logic          accept;
    logic [N-1:0]  rd_a;

    // The acceptance condition only needs the registered state; cmd_ready
    // itself never depends on cmd_valid.
    assign accept = cmd_valid && (state_q == S_IDLE);

    // READ sources its data straight from the file at the accepting edge.
    assign rd_a = rf_q[cmd_addr_a];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode; outputs depend on state_q only
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = (cmd_kind == KIND_EXEC) ? S_FETCH : S_RESP;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latch the EXEC-relevant command fields when a command is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_d_q <= '0;
            opcode_q <= '0;
        end else if (accept) begin
            addr_a_q <= cmd_addr_a;
            addr_b_q <= cmd_addr_b;
            addr_d_q <= cmd_addr_d;
            opcode_q <= cmd_opcode;
        end
    end

    // Drive the ALU operands in FETCH; they hold their values otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
        end else if (state_q == S_FETCH) begin
            alu_a_q      <= rf_q[addr_a_q];
            alu_b_q      <= rf_q[addr_b_q];
            alu_opcode_q <= opcode_q;
        end
    end

    // Register file writes: LOAD at accept, EXEC result at the end of EXEC.
    // Operands were captured in FETCH, so a destination equal to a source
    // sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (accept && (cmd_kind == KIND_LOAD)) begin
            rf_q[cmd_addr_d] <= cmd_imm;
        end else if (state_q == S_EXEC) begin
            rf_q[addr_d_q] <= alu_y;
        end
    end

    // Response payload; frozen while the response waits in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_c_q    <= 1'b0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else if (accept && (cmd_kind != KIND_EXEC)) begin
            rsp_c_q <= 1'b0;
            case (cmd_kind)
                KIND_LOAD: begin
                    rsp_data_q <= cmd_imm;
                    rsp_zero_q <= (cmd_imm == '0);
                    rsp_err_q  <= 1'b0;
                end
                KIND_READ: begin
                    rsp_data_q <= rd_a;
                    rsp_zero_q <= (rd_a == '0);
                    rsp_err_q  <= 1'b0;
                end
                default: begin
                    rsp_data_q <= '0;
                    rsp_zero_q <= 1'b0;
                    rsp_err_q  <= 1'b1;
                end
            endcase
        end else if (state_q == S_EXEC) begin
            rsp_data_q <= alu_y;
            rsp_c_q    <= alu_c;
            rsp_zero_q <= alu_zero;
            rsp_err_q  <= 1'b0;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_c      = rsp_c_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU attached.
module tb_alu_cmd_sequencer;

    localparam int N  = 8;
    localparam int AW = 3;

    localparam logic [1:0] K_EXEC = 2'b00;
    localparam logic [1:0] K_LOAD = 2'b01;
    localparam logic [1:0] K_READ = 2'b10;
    localparam logic [1:0] K_RSVD = 2'b11;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b101;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_kind;
    logic [2:0]    cmd_opcode;
    logic [AW-1:0] cmd_addr_a;
    logic [AW-1:0] cmd_addr_b;
    logic [AW-1:0] cmd_addr_d;
    logic [N-1:0]  cmd_imm;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [2:0]    alu_opcode;
    logic [N-1:0]  alu_y;
    logic          alu_c;
    logic          alu_zero;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_data;
    logic          rsp_c;
    logic          rsp_zero;
    logic          rsp_err;

    int total = 0;
    int bad   = 0;

    alu_cmd_sequencer #(.N(N), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_kind   (cmd_kind),
        .cmd_opcode (cmd_opcode),
        .cmd_addr_a (cmd_addr_a),
        .cmd_addr_b (cmd_addr_b),
        .cmd_addr_d (cmd_addr_d),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_y      (alu_y),
        .alu_c      (alu_c),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_c      (rsp_c),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU: carry-out for ADD, borrow for SUB
    always_comb begin
        logic [N:0] wide;
        wide = '0;
        case (alu_opcode)
            3'b000:  wide = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  wide = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  wide = {1'b0, alu_a & alu_b};
            3'b011:  wide = {1'b0, alu_a | alu_b};
            3'b100:  wide = {1'b0, ~alu_a};
            3'b101:  wide = {1'b0, alu_a ^ alu_b};
            3'b110:  wide = {1'b0, alu_a << alu_b[2:0]};
            default: wide = {1'b0, alu_a >> alu_b[2:0]};
        endcase
        alu_y    = wide[N-1:0];
        alu_c    = wide[N];
        alu_zero = (wide[N-1:0] == '0);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one command for a single accepting edge (caller ensures IDLE)
    task automatic issue(input logic [1:0] kind, input logic [2:0] op,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input logic [N-1:0] imm);
        cmd_kind   = kind;
        cmd_opcode = op;
        cmd_addr_a = a;
        cmd_addr_b = b;
        cmd_addr_d = d;
        cmd_imm    = imm;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
    endtask

    // Count edges from the accepting edge until rsp_valid is seen
    task automatic wait_rsp(input string tag, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) chk({tag, "_timeout"}, 16'(rsp_valid), 16'(1));
    endtask

    // Full transaction with rsp_ready high: checks latency, payload, return to IDLE
    task automatic run(input string tag, input logic [1:0] kind, input logic [2:0] op,
                       input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input logic [N-1:0] imm,
                       input logic [N-1:0] e_data, input logic e_c,
                       input logic e_z, input logic e_err, input int e_lat);
        int lat;
        chk({tag, "_rdy"}, 16'(cmd_ready), 16'(1));
        issue(kind, op, a, b, d, imm);
        wait_rsp(tag, lat);
        chk({tag, "_lat"},  16'(lat),      16'(e_lat));
        chk({tag, "_data"}, 16'(rsp_data), 16'(e_data));
        chk({tag, "_c"},    16'(rsp_c),    16'(e_c));
        chk({tag, "_z"},    16'(rsp_zero), 16'(e_z));
        chk({tag, "_err"},  16'(rsp_err),  16'(e_err));
        @(posedge clk);
        #1;
        chk({tag, "_done"}, 16'({rsp_valid, cmd_ready}), 16'(2'b01));
    endtask

    initial begin
        int lat;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_kind   = '0;
        cmd_opcode = '0;
        cmd_addr_a = '0;
        cmd_addr_b = '0;
        cmd_addr_d = '0;
        cmd_imm    = '0;
        rsp_ready  = 1'b1;
        #1;
        chk("rst_rdy",  16'(cmd_ready), 16'(1));
        chk("rst_vld",  16'(rsp_valid), 16'(0));
        chk("rst_alu",  16'({alu_a, alu_b, alu_opcode}), 16'(0));
        chk("rst_rsp",  16'({rsp_data, rsp_c, rsp_zero, rsp_err}), 16'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD without carry, then read back
        run("ld_r1",  K_LOAD, OP_ADD, 3'd0, 3'd0, 3'd1, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 1);
        run("ld_r2",  K_LOAD, OP_ADD, 3'd0, 3'd0, 3'd2, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1);
        run("add_r3", K_EXEC, OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 3);
        chk("add_alu", 16'({alu_a, alu_b}), 16'h0F01);
        chk("add_op",  16'(alu_opcode), 16'(OP_ADD));
        run("rd_r3",  K_READ, OP_ADD, 3'd3, 3'd0, 3'd0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1);

        // SUB with borrow and SUB to zero
        run("ld_r4",  K_LOAD, OP_ADD, 3'd0, 3'd0, 3'd4, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        run("ld_r5",  K_LOAD, OP_ADD, 3'd0, 3'd0, 3'd5, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1);
        run("sub_r6", K_EXEC, OP_SUB, 3'd4, 3'd5, 3'd6, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3);
        run("sub_r7", K_EXEC, OP_SUB, 3'd5, 3'd5, 3'd7, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3);
        run("rd_r6",  K_READ, OP_ADD, 3'd6, 3'd0, 3'd0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1);
        run("rd_r4",  K_READ, OP_ADD, 3'd4, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1);

        // Source equals destination: uses the old r1
        run("ld_r1b", K_LOAD, OP_ADD, 3'd0, 3'd0, 3'd1, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0, 1);
        run("add_r1", K_EXEC, OP_ADD, 3'd1, 3'd1, 3'd1, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 3);
        run("rd_r1",  K_READ, OP_ADD, 3'd1, 3'd0, 3'd0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1);

        // Back-pressure: r0 = r3 ^ r1 = 0x10 ^ 0x02 = 0x12, held for 5 cycles
        rsp_ready = 1'b0;
        issue(K_EXEC, OP_XOR, 3'd3, 3'd1, 3'd0, 8'h00);
        wait_rsp("stall", lat);
        chk("stall_lat", 16'(lat), 16'(3));
        cmd_kind   = K_READ;
        cmd_addr_a = 3'd0;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld",  16'(rsp_valid), 16'(1));
            chk("stall_rdy",  16'(cmd_ready), 16'(0));
            chk("stall_data", 16'({rsp_data, rsp_c, rsp_zero, rsp_err}), 16'({8'h12, 3'b000}));
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_idle", 16'({rsp_valid, cmd_ready}), 16'(2'b01));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("next_acc",  16'({rsp_valid, cmd_ready}), 16'(2'b10));
        chk("next_data", 16'(rsp_data), 16'h12);
        @(posedge clk);
        #1;

        // Reserved kind: error response, no write to r2
        run("rsvd",   K_RSVD, OP_ADD, 3'd0, 3'd0, 3'd2, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1, 1);
        run("rd_r2",  K_READ, OP_ADD, 3'd2, 3'd0, 3'd0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1);

        // Reset during FETCH aborts the command and clears the file
        run("ld_r3",  K_LOAD, OP_ADD, 3'd0, 3'd0, 3'd3, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0, 1);
        issue(K_EXEC, OP_XOR, 3'd3, 3'd3, 3'd3, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("abort_vld", 16'(rsp_valid), 16'(0));
        chk("abort_rdy", 16'(cmd_ready), 16'(1));
        chk("abort_rsp", 16'({rsp_data, rsp_err}), 16'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("abort_hold", 16'({rsp_valid, cmd_ready}), 16'(2'b01));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("rd_r3z", K_READ, OP_ADD, 3'd3, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        run("rd_r1z", K_READ, OP_ADD, 3'd1, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven sequencer that sits in front of the combinational ALU and acts as its initiator. It owns a small register file, accepts LOAD / READ / EXEC commands on a valid/ready channel, fetches operands and drives the ALU's operand and opcode inputs from registers, then writes the result back. It returns one response per command on a second valid/ready channel, carrying the result data and the ALU flags.

## Interface
- N, 8, data width; must match the ALU width.
- AW, 3, register-file address width; the file holds 2^AW words of N bits.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_kind  in  2  command kind: 00 EXEC, 01 LOAD, 10 READ, 11 reserved.
- cmd_opcode  in  3  ALU opcode (ADD 000, SUB 001, AND 010, OR 011, NOT 100, XOR 101, SLL 110, SRL 111).
- cmd_addr_a  in  AW  source A address (EXEC and READ).
- cmd_addr_b  in  AW  source B address (EXEC).
- cmd_addr_d  in  AW  destination address (EXEC and LOAD).
- cmd_imm  in  N  immediate value (LOAD).
- alu_a  out  N  registered operand A to the ALU.
- alu_b  out  N  registered operand B to the ALU.
- alu_opcode  out  3  registered opcode to the ALU.
- alu_y  in  N  ALU result.
- alu_c  in  1  ALU carry/borrow.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  N  response data.
- rsp_c  out  1  response carry.
- rsp_zero  out  1  response zero flag.
- rsp_err  out  1  high when the command kind was reserved.

## Operation
- FSM states: IDLE, FETCH, EXEC, RESP. One command is in flight at a time.
- IDLE: cmd_ready=1. A command is accepted when cmd_valid && cmd_ready; all cmd_* fields are latched at that edge.
  - EXEC kind goes to FETCH.
  - All other kinds go to RESP.
- FETCH (EXEC only): at the edge, alu_a<=rf[addr_a], alu_b<=rf[addr_b], alu_opcode<=opcode. Next state EXEC.
- EXEC: the ALU settles combinationally within this cycle. At the edge:
  - rf[addr_d]<=alu_y.
  - rsp_data<=alu_y, rsp_c<=alu_c, rsp_zero<=alu_zero, rsp_err<=0.
  - Next state RESP.
- LOAD: at the accepting edge, rf[addr_d]<=imm, rsp_data<=imm, rsp_c<=0, rsp_zero<=(imm==0), rsp_err<=0.
- READ: at the accepting edge, rsp_data<=rf[addr_a], rsp_c<=0, rsp_zero<=(rf[addr_a]==0), rsp_err<=0. No write.
- Reserved kind (11): at the accepting edge, rsp_data<=0, rsp_c<=0, rsp_zero<=0, rsp_err<=1. No write.
- RESP: rsp_valid=1. Hold until rsp_valid && rsp_ready, then go to IDLE.
- Source equal to destination is legal. Operands are read in FETCH, before the write in EXEC, so r1=r1+r1 uses the old r1.
- Outside FETCH, alu_a, alu_b and alu_opcode hold their last values.
- Reset: all state is cleared asynchronously.
  - State goes to IDLE and every rf word goes to 0.
  - alu_a, alu_b, alu_opcode, rsp_data, rsp_c, rsp_zero, rsp_err go to 0; rsp_valid goes to 0 and cmd_ready goes to 1.
  - Reset mid-command aborts it: no write and no response.

## Timing
- cmd_ready and rsp_valid are decoded from the registered state only; neither depends combinationally on any input.
- EXEC latency: rsp_valid rises after the 3rd rising edge counting the accepting edge (accept, FETCH, EXEC). The register write occurs at the same edge.
- LOAD/READ/reserved latency: rsp_valid rises after the accepting edge.
- rsp_data, rsp_c, rsp_zero and rsp_err are stable while rsp_valid=1 && rsp_ready=0.
- The handshake edge returns the FSM to IDLE. The earliest next accept is the following edge, so there is no accept in the same cycle as a response handshake.
- Minimum command period: 4 cycles for EXEC, 2 for the other kinds, with rsp_ready tied high.

## Test plan
- LOAD r1=0x0F, LOAD r2=0x01, EXEC ADD r3=r1+r2 -> rsp 0x10/c0/z0 three edges after accept; READ r3 -> 0x10.
- LOAD r4=0x00, r5=0x01; EXEC SUB r6=r4-r5 -> rsp 0xFF, c=1, zero=0; EXEC SUB r7=r5-r5 -> 0x00, zero=1.
- LOAD r1=0x81, EXEC ADD r1=r1+r1 -> rsp 0x02, c=1; READ r1 -> 0x02.
- EXEC in flight with rsp_ready held low 5 cycles -> rsp_valid stays high, rsp fields stable, cmd_ready=0 throughout; accepted one edge after the handshake.
- cmd_kind=11 with addr_d=2 -> rsp_err=1, rsp_data=0; READ r2 unchanged.
- LOAD r3=0xAA, then assert rst_n=0 during FETCH of EXEC r3=r3 XOR r3 -> rsp_valid=0 immediately, cmd_ready=1; after release READ r3 -> 0x00.
